rgb_fade_sequencer: RTL and testbench

Colour-sequence controller for the three-channel RGB PWM datapath. It replaces the three free-running per-channel ramps with one coordinated scheduler. The scheduler steps through a fixed six-entry hue keyframe table and holds each colour. It linearly crossfades all three duty values toward the next keyframe and drives the red/green/blue pwm duty_cycle inputs directly.

---
 rtl/rgb_fade_sequencer_pkg.sv | 52 +++++
 rtl/rgb_fade_sequencer_tick_prescaler.sv | 29 ++
 rtl/rgb_fade_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types and helpers for the RGB fade sequencer: FSM states, the
// hue keyframe table, keyframe index wrap and the crossfade interpolation step.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FADE = 2'd2
    } state_t;

    localparam int NUM_KEYS = 6;
    localparam int CH_R     = 0;
    localparam int CH_G     = 1;
    localparam int CH_B     = 2;

    function automatic logic [2:0] key_next(input logic [2:0] idx);
        return (idx == 3'(NUM_KEYS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    // Level of one channel at a keyframe: either 0 or full scale 2^duty_w-1.
    function automatic logic [31:0] key_level(input logic [2:0] idx, input int ch,
                                              input int duty_w);
        logic [2:0] mask;
        logic       sel;
        case (idx)
            3'd0:    mask = 3'b100;
            3'd1:    mask = 3'b110;
            3'd2:    mask = 3'b010;
            3'd3:    mask = 3'b011;
            3'd4:    mask = 3'b001;
            3'd5:    mask = 3'b101;
            default: mask = 3'b100;
        endcase
        case (ch)
            CH_R:    sel = mask[2];
            CH_G:    sel = mask[1];
            default: sel = mask[0];
        endcase
        return sel ? ((32'd1 << duty_w) - 32'd1) : 32'd0;
    endfunction

    // 32-bit signed holds (to-from)*step exactly for duty widths up to 16 bits.
    function automatic logic signed [31:0] lerp_step(input logic signed [31:0] from_v,
                                                     input logic signed [31:0] to_v,
                                                     input logic signed [31:0] step_v,
                                                     input int shift);
        logic signed [31:0] prod;
        prod = (to_v - from_v) * step_v;
        return from_v + (prod >>> shift);
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_prescaler.sv
// Free-running tick divider: one-cycle tick every TICK_DIV enabled clocks.
// clear forces the count back to zero and wins over run.
module tick_prescaler #(
    parameter int TICK_DIV = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign tick   = run && !clear && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// Coordinated RGB colour scheduler: holds each hue keyframe, then linearly
// crossfades all three duty values to the next keyframe on sequencer ticks.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int TICK_DIV   = 120000,
    parameter int FADE_STEPS = 32,
    parameter int HOLD_TICKS = 50,
    parameter int DUTY_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pause,
    input  logic              next_req,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic              duty_update,
    output logic [2:0]        key_idx,
    output logic [1:0]        state_o
);
    localparam int STEP_SH = $clog2(FADE_STEPS);
    localparam int STEP_W  = $clog2(FADE_STEPS + 1);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

    state_t              r_state, w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt, w_hold_inc;
    logic [STEP_W-1:0]   r_step, w_step_nxt, w_step_inc;
    logic [2:0]          r_key_idx, w_key_nxt, w_key_to;
    logic [DUTY_W-1:0]   r_duty_r, r_duty_g, r_duty_b;
    logic [DUTY_W-1:0]   w_duty_r_nxt, w_duty_g_nxt, w_duty_b_nxt;
    logic                r_duty_update, w_update_nxt;
    logic                w_tick, w_run, w_clear, w_skip, w_hold_done, w_fade_done;

    assign w_skip      = enable && !pause && (r_state == ST_HOLD) && next_req;
    assign w_run       = enable && !pause && (r_state != ST_IDLE);
    assign w_clear     = !enable || (r_state == ST_IDLE) || w_skip;
    assign w_hold_inc  = r_hold_cnt + 1'b1;
    assign w_step_inc  = r_step + 1'b1;
    assign w_hold_done = (w_hold_inc == HOLD_W'(HOLD_TICKS));
    assign w_fade_done = (w_step_inc == STEP_W'(FADE_STEPS));
    assign w_key_to    = key_next(r_key_idx);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (!pause) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_HOLD;
                ST_HOLD: if (next_req || (w_tick && w_hold_done)) w_state_nxt = ST_FADE;
                ST_FADE: if (w_tick && w_fade_done) w_state_nxt = ST_HOLD;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counter and duty updates; pause leaves everything at its default (hold).
    always_comb begin
        w_hold_nxt   = r_hold_cnt;
        w_step_nxt   = r_step;
        w_key_nxt    = r_key_idx;
        w_duty_r_nxt = r_duty_r;
        w_duty_g_nxt = r_duty_g;
        w_duty_b_nxt = r_duty_b;
        w_update_nxt = 1'b0;
        if (!enable) begin
            w_hold_nxt   = '0;
            w_step_nxt   = '0;
            w_key_nxt    = 3'd0;
            w_duty_r_nxt = '0;
            w_duty_g_nxt = '0;
            w_duty_b_nxt = '0;
            w_update_nxt = |{r_duty_r, r_duty_g, r_duty_b};
        end else if (!pause) begin
            case (r_state)
                ST_IDLE: begin
                    w_hold_nxt   = '0;
                    w_step_nxt   = '0;
                    w_key_nxt    = 3'd0;
                    w_duty_r_nxt = DUTY_W'(key_level(3'd0, CH_R, DUTY_W));
                    w_duty_g_nxt = DUTY_W'(key_level(3'd0, CH_G, DUTY_W));
                    w_duty_b_nxt = DUTY_W'(key_level(3'd0, CH_B, DUTY_W));
                    w_update_nxt = 1'b1;
                end
                ST_HOLD: begin
                    if (next_req || (w_tick && w_hold_done)) begin
                        w_hold_nxt = '0;
                        w_step_nxt = '0;
                    end else if (w_tick) begin
                        w_hold_nxt = w_hold_inc;
                    end
                end
                ST_FADE: begin
                    if (w_tick) begin
                        w_duty_r_nxt = DUTY_W'(lerp_step(
                            $signed(key_level(r_key_idx, CH_R, DUTY_W)),
                            $signed(key_level(w_key_to, CH_R, DUTY_W)),
                            $signed(32'(w_step_inc)), STEP_SH));
                        w_duty_g_nxt = DUTY_W'(lerp_step(
                            $signed(key_level(r_key_idx, CH_G, DUTY_W)),
                            $signed(key_level(w_key_to, CH_G, DUTY_W)),
                            $signed(32'(w_step_inc)), STEP_SH));
                        w_duty_b_nxt = DUTY_W'(lerp_step(
                            $signed(key_level(r_key_idx, CH_B, DUTY_W)),
                            $signed(key_level(w_key_to, CH_B, DUTY_W)),
                            $signed(32'(w_step_inc)), STEP_SH));
                        w_update_nxt = 1'b1;
                        if (w_fade_done) begin
                            w_key_nxt  = w_key_to;
                            w_step_nxt = '0;
                            w_hold_nxt = '0;
                        end else begin
                            w_step_nxt = w_step_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt    <= '0;
            r_step        <= '0;
            r_key_idx     <= 3'd0;
            r_duty_r      <= '0;
            r_duty_g      <= '0;
            r_duty_b      <= '0;
            r_duty_update <= 1'b0;
        end else begin
            r_hold_cnt    <= w_hold_nxt;
            r_step        <= w_step_nxt;
            r_key_idx     <= w_key_nxt;
            r_duty_r      <= w_duty_r_nxt;
            r_duty_g      <= w_duty_g_nxt;
            r_duty_b      <= w_duty_b_nxt;
            r_duty_update <= w_update_nxt;
        end
    end

    assign duty_r      = r_duty_r;
    assign duty_g      = r_duty_g;
    assign duty_b      = r_duty_b;
    assign duty_update = r_duty_update;
    assign key_idx     = r_key_idx;
    assign state_o     = r_state;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: directed stimulus, expected duty loads queued
// with their spacing in clocks, checked by a monitor on every duty_update.
module tb_rgb_fade_sequencer;
    localparam int TICK_DIV   = 4;
    localparam int FADE_STEPS = 4;
    localparam int HOLD_TICKS = 2;
    localparam int DUTY_W     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              pause = 1'b0;
    logic              next_req = 1'b0;
    logic [DUTY_W-1:0] duty_r, duty_g, duty_b;
    logic              duty_update;
    logic [2:0]        key_idx;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    logic [28:0] exp_q[$];
    int          gap_q[$];

    rgb_fade_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .FADE_STEPS(FADE_STEPS),
        .HOLD_TICKS(HOLD_TICKS),
        .DUTY_W    (DUTY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pause      (pause),
        .next_req   (next_req),
        .duty_r     (duty_r),
        .duty_g     (duty_g),
        .duty_b     (duty_b),
        .duty_update(duty_update),
        .key_idx    (key_idx),
        .state_o    (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // gap = clocks since the previous duty load (0: not checked)
    task automatic push(input int gap, input logic [1:0] st, input logic [2:0] k,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_q.push_back({st, k, r, g, b});
        gap_q.push_back(gap);
    endtask

    task automatic wait_updates(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = 40 * n + 40;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (duty_update) seen++;
            budget--;
        end
        if (seen < n) begin
            n_checks++;
            $display("FAIL wait_updates: saw %0d of %0d duty loads", seen, n);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r"}, int'(duty_r), 0);
        check({tag, "_g"}, int'(duty_g), 0);
        check({tag, "_b"}, int'(duty_b), 0);
        check({tag, "_upd"}, int'(duty_update), 0);
        check({tag, "_key"}, int'(key_idx), 0);
        check({tag, "_state"}, int'(state_o), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [28:0] act;
        logic [28:0] e;
        int          g;
        if (rst_n && duty_update) begin
            act = {state_o, key_idx, duty_r, duty_g, duty_b};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_load: got st=%0d key=%0d rgb=%0d,%0d,%0d expected none",
                         state_o, key_idx, duty_r, duty_g, duty_b);
            end else begin
                e = exp_q.pop_front();
                g = gap_q.pop_front();
                if (act == e) n_pass++;
                else $display("FAIL load_value: got st=%0d key=%0d rgb=%0d,%0d,%0d expected st=%0d key=%0d rgb=%0d,%0d,%0d",
                              act[28:27], act[26:24], act[23:16], act[15:8], act[7:0],
                              e[28:27], e[26:24], e[23:16], e[15:8], e[7:0]);
                if (g != 0) check("load_spacing", cyc - last_cyc, g);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        // reset held with enable high
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_state", int'(state_o), 0);

        // start: key 0 loaded the cycle after enable
        push(0, 2'd1, 3'd0, 8'd255, 8'd0, 8'd0);
        enable = 1'b1;
        @(negedge clk);
        check("start_state", int'(state_o), 1);
        check("start_update", int'(duty_update), 1);
        @(negedge clk);
        check("start_strobe_once", int'(duty_update), 0);

        // one full colour cycle
        push(12, 2'd2, 3'd0, 8'd255, 8'd63,  8'd0);
        push(4,  2'd2, 3'd0, 8'd255, 8'd127, 8'd0);
        push(4,  2'd2, 3'd0, 8'd255, 8'd191, 8'd0);
        push(4,  2'd1, 3'd1, 8'd255, 8'd255, 8'd0);
        push(12, 2'd2, 3'd1, 8'd191, 8'd255, 8'd0);
        push(4,  2'd2, 3'd1, 8'd127, 8'd255, 8'd0);
        push(4,  2'd2, 3'd1, 8'd63,  8'd255, 8'd0);
        push(4,  2'd1, 3'd2, 8'd0,   8'd255, 8'd0);
        push(12, 2'd2, 3'd2, 8'd0,   8'd255, 8'd63);
        push(4,  2'd2, 3'd2, 8'd0,   8'd255, 8'd127);
        push(4,  2'd2, 3'd2, 8'd0,   8'd255, 8'd191);
        push(4,  2'd1, 3'd3, 8'd0,   8'd255, 8'd255);
        push(12, 2'd2, 3'd3, 8'd0,   8'd191, 8'd255);
        push(4,  2'd2, 3'd3, 8'd0,   8'd127, 8'd255);
        push(4,  2'd2, 3'd3, 8'd0,   8'd63,  8'd255);
        push(4,  2'd1, 3'd4, 8'd0,   8'd0,   8'd255);
        push(12, 2'd2, 3'd4, 8'd63,  8'd0,   8'd255);
        push(4,  2'd2, 3'd4, 8'd127, 8'd0,   8'd255);
        push(4,  2'd2, 3'd4, 8'd191, 8'd0,   8'd255);
        push(4,  2'd1, 3'd5, 8'd255, 8'd0,   8'd255);
        push(12, 2'd2, 3'd5, 8'd255, 8'd0,   8'd191);
        push(4,  2'd2, 3'd5, 8'd255, 8'd0,   8'd127);
        push(4,  2'd2, 3'd5, 8'd255, 8'd0,   8'd63);
        push(4,  2'd1, 3'd0, 8'd255, 8'd0,   8'd0);
        wait_updates(24);

        // pause for 20 clocks after the second fade step
        push(12, 2'd2, 3'd0, 8'd255, 8'd63,  8'd0);
        push(4,  2'd2, 3'd0, 8'd255, 8'd127, 8'd0);
        push(24, 2'd2, 3'd0, 8'd255, 8'd191, 8'd0);
        push(4,  2'd1, 3'd1, 8'd255, 8'd255, 8'd0);
        wait_updates(2);
        pause = 1'b1;
        begin
            int loads;
            loads = 0;
            repeat (20) begin
                @(negedge clk);
                if (duty_update) loads++;
            end
            check("pause_no_load", loads, 0);
        end
        check("pause_state", int'(state_o), 2);
        check("pause_duty_g", int'(duty_g), 127);
        pause = 1'b0;
        wait_updates(2);

        // next_req while paused in HOLD is dropped
        push(14, 2'd2, 3'd1, 8'd191, 8'd255, 8'd0);
        pause    = 1'b1;
        next_req = 1'b1;
        @(negedge clk);
        next_req = 1'b0;
        check("pause_drops_skip", int'(state_o), 1);
        @(negedge clk);
        pause = 1'b0;
        wait_updates(1);

        // next_req in FADE is ignored
        push(4, 2'd2, 3'd1, 8'd127, 8'd255, 8'd0);
        push(4, 2'd2, 3'd1, 8'd63,  8'd255, 8'd0);
        push(4, 2'd1, 3'd2, 8'd0,   8'd255, 8'd0);
        next_req = 1'b1;
        @(negedge clk);
        next_req = 1'b0;
        check("fade_ignores_skip", int'(state_o), 2);
        wait_updates(3);

        // next_req coincident with the first HOLD tick wins
        push(8, 2'd2, 3'd2, 8'd0, 8'd255, 8'd63);
        push(4, 2'd2, 3'd2, 8'd0, 8'd255, 8'd127);
        repeat (3) @(negedge clk);
        next_req = 1'b1;
        @(negedge clk);
        next_req = 1'b0;
        check("skip_state", int'(state_o), 2);
        wait_updates(2);

        // disable mid-fade
        push(1, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0);
        enable = 1'b0;
        @(negedge clk);
        check("disable_update", int'(duty_update), 1);
        repeat (4) @(negedge clk);
        check("disable_idle", int'(state_o), 0);

        // re-enable restarts at key 0, then async reset mid-fade
        push(0,  2'd1, 3'd0, 8'd255, 8'd0,  8'd0);
        push(12, 2'd2, 3'd0, 8'd255, 8'd63, 8'd0);
        enable = 1'b1;
        @(negedge clk);
        check("restart_key", int'(key_idx), 0);
        check("restart_r", int'(duty_r), 255);
        wait_updates(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", int'(state_o), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
